// File: rtl/fp_mult_pkg.sv
// Shared constants and FSM state type for the sequential mantissa multiplier.
package fp_mult_pkg;

  localparam int FP_EXP_BIAS = 127;
  localparam int FP_MANT_W   = 24;
  localparam int FP_PROD_W   = 2 * FP_MANT_W;
  localparam int FP_EXP_W    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mm_state_e;

endpackage

// File: rtl/mant_mult_seq.sv
// Sequential unsigned mantissa multiplier for single-precision FP multiply.
// Accepts an operand pair in IDLE, iterates shift-add in MUL, and holds the
// product, biased exponent sum and sign in DONE until the consumer takes it.
// Optional macro RADIX4_EN: retire two multiplier bits per cycle (MANT_W/2
// steps) instead of one; the product is bit-identical in both builds.
module mant_mult_seq
  import fp_mult_pkg::*;
#(
  parameter int EXP_BIAS = FP_EXP_BIAS,
  parameter int MANT_W   = FP_MANT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           a,
  input  logic [31:0]           b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*MANT_W-1:0]   P,
  output logic [FP_EXP_W-1:0]   exp_out,
  output logic                  sign_out
);

  localparam int PW    = 2 * MANT_W;
`ifdef RADIX4_EN
  localparam int STEPS = MANT_W / 2;
`else
  localparam int STEPS = MANT_W;
`endif
  localparam int CNT_W = $clog2(MANT_W + 1);

  mm_state_e             state_q, state_d;
  logic [PW-1:0]         prod_q, prod_d;
  logic [MANT_W-1:0]     mcand_q, mcand_d;
  logic [MANT_W-1:0]     mplr_q, mplr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FP_EXP_W-1:0]   exp_q, exp_d;
  logic                  sign_q, sign_d;
`ifdef RADIX4_EN
  logic [MANT_W+1:0]     mult3_q, mult3_d;
  logic [MANT_W+1:0]     addend4;
  logic [MANT_W+1:0]     sum4;
`else
  logic [MANT_W:0]       sum2;
`endif
  logic [FP_EXP_W-1:0]   exp_a, exp_b;

  assign exp_a = FP_EXP_W'(a[30:23]);
  assign exp_b = FP_EXP_W'(b[30:23]);

`ifdef RADIX4_EN
  // Radix-4 step: add 0/1x/2x/3x multiplicand to the upper half, shift by 2.
  always_comb begin
    addend4 = '0;
    case (mplr_q[1:0])
      2'd1:    addend4 = {2'b00, mcand_q};
      2'd2:    addend4 = {1'b0, mcand_q, 1'b0};
      2'd3:    addend4 = mult3_q;
      default: addend4 = '0;
    endcase
    sum4 = {2'b00, prod_q[PW-1:MANT_W]} + addend4;
  end
`else
  // Radix-2 step: conditionally add multiplicand to the upper half, shift by 1.
  always_comb begin
    sum2 = {1'b0, prod_q[PW-1:MANT_W]} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
  end
`endif

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
`ifdef RADIX4_EN
    mult3_d = mult3_q;
`endif
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = MANT_W'({|a[30:23], a[22:0]});
          mplr_d  = MANT_W'({|b[30:23], b[22:0]});
          prod_d  = '0;
          cnt_d   = '0;
          sign_d  = a[31] ^ b[31];
          exp_d   = exp_a + exp_b - FP_EXP_W'(EXP_BIAS);
`ifdef RADIX4_EN
          mult3_d = {2'b00, mcand_d} + {1'b0, mcand_d, 1'b0};
`endif
          state_d = MUL;
        end
      end
      MUL: begin
`ifdef RADIX4_EN
        prod_d = {sum4, prod_q[MANT_W-1:2]};
        mplr_d = mplr_q >> 2;
`else
        prod_d = {sum2, prod_q[MANT_W-1:1]};
        mplr_d = mplr_q >> 1;
`endif
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(STEPS - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prod_q  <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
`ifdef RADIX4_EN
      mult3_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
`ifdef RADIX4_EN
      mult3_q <= mult3_d;
`endif
    end
  end

  assign P        = prod_q;
  assign exp_out  = exp_q;
  assign sign_out = sign_q;

endmodule

// File: tb/tb_mant_mult_seq.sv
// Scoreboard bench for mant_mult_seq: driver pushes expected results on
// accept, a negedge monitor compares whenever the DUT presents a result.
module tb_mant_mult_seq;

`ifdef RADIX4_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 24;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] P;
  logic [9:0]  exp_out;
  logic        sign_out;

  mant_mult_seq #(.EXP_BIAS(127), .MANT_W(24)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .P(P), .exp_out(exp_out), .sign_out(sign_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   seen  = 0;
  bit   post  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares presented results against the scoreboard head.
  always @(negedge clk) begin
    if (post) begin
      post = 0;
      chk("idle_after_consume", {62'd0, out_valid, in_ready}, 64'd1);
    end
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        if (!seen) begin
          seen = 1;
          chk("latency", 64'(cyc - sb[0].acc), 64'(LAT));
          chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
        end
        if (!out_ready) begin
          chk("hold_P", {16'd0, P}, {16'd0, sb[0].p});
          chk("hold_exp", {54'd0, exp_out}, {54'd0, sb[0].e});
        end else begin
          chk("P", {16'd0, P}, {16'd0, sb[0].p});
          chk("exp_out", {54'd0, exp_out}, {54'd0, sb[0].e});
          chk("sign_out", {63'd0, sign_out}, {63'd0, sb[0].s});
          void'(sb.pop_front());
          seen = 0;
          post = 1;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_,
                       input logic [47:0] ep, input logic [9:0] ee, input logic es);
    exp_t x;
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    in_valid = 1'b1; a = ta; b = tb_;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x.p = ep; x.e = ee; x.s = es; x.acc = cyc;
    sb.push_back(x);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (sb.size() != 0 || !in_ready) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_P", {16'd0, P}, 64'd0);
    chk("rst_exp", {54'd0, exp_out}, 64'd0);
    chk("rst_sign", {63'd0, sign_out}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(32'h3F800000, 32'h3F800000, 48'h400000000000, 10'd127, 1'b0);
    issue(32'h3FFFFFFF, 32'h3FFFFFFF, 48'hFFFFFE000001, 10'd127, 1'b0);
    issue(32'hC0000000, 32'h40400000, 48'h600000000000, 10'd129, 1'b1);
    issue(32'h00800000, 32'h00800000, 48'h400000000000, 10'h383, 1'b0);
    issue(32'h00000000, 32'h3F800000, 48'h000000000000, 10'd0,   1'b0);
    issue(32'h00000001, 32'h3F800000, 48'h000000800000, 10'd0,   1'b0);
    issue(32'h80000000, 32'h7F800000, 48'h000000000000, 10'd128, 1'b1);
    issue(32'h3FC00000, 32'h3FC00000, 48'h900000000000, 10'd127, 1'b0);
    wait_idle();

    // Back-pressure: result held for 10 cycles while in_valid pulses.
    out_ready = 1'b0;
    issue(32'h3F800000, 32'h3FC00000, 48'h600000000000, 10'd127, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid; a = 32'hFFFFFFFF; b = 32'h12345678;
      @(posedge clk); #1;
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // Reset in the middle of MUL discards the operation.
    issue(32'h3F800000, 32'h3F800000, 48'h400000000000, 10'd127, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_P", {16'd0, P}, 64'd0);
    void'(sb.pop_front());
    @(posedge clk); #1;
    rst = 1'b0;
    issue(32'hC0000000, 32'h40400000, 48'h600000000000, 10'd129, 1'b1);
    wait_idle();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mant_mult_seq.md
MANT_MULT_SEQ -- requirements
Module: mant_mult_seq

Interface
REQ-001 SHALL have parameter EXP_BIAS, default 127, the exponent bias subtracted from the exponent sum.
REQ-002 SHALL have parameter MANT_W, default 24, the mantissa width including the hidden bit.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, operand pair present.
REQ-006 SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-007 SHALL have ports a and b, input, 32 each, IEEE-754 single-precision operands.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, downstream normalize stage accepts the result.
REQ-010 SHALL have port P, output, 48, unsigned mantissa product.
REQ-011 SHALL have port exp_out, output, 10, biased exponent sum (two's complement, modulo 2^10).
REQ-012 SHALL have port sign_out, output, 1, product sign.

Function
REQ-013 SHALL implement FSM states IDLE, MUL and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept SHALL occur on a clock edge with in_valid && in_ready; the FSM then enters MUL.
REQ-016 On accept, SHALL load mantissas {|a[30:23], a[22:0]} and {|b[30:23], b[22:0]} (hidden bit 0 when the exponent field is 0), clear the accumulator and clear the step counter.
REQ-017 On accept, SHALL register sign_out = a[31]^b[31] and exp_out = {2'b0,a[30:23]} + {2'b0,b[30:23]} - EXP_BIAS, truncated to 10 bits.
REQ-018 Without RADIX4_EN, MUL SHALL perform one shift-add step per cycle (add multiplicand to upper accumulator half if multiplier LSB is 1, then shift right 1), MANT_W steps total.
REQ-019 After the final step, the FSM SHALL enter DONE; out_valid SHALL first be high exactly MANT_W cycles after the accept edge (24 by default).
REQ-020 In DONE, P, exp_out and sign_out SHALL hold stable while out_ready = 0.
REQ-021 In DONE with out_ready = 1, the result SHALL be consumed and the FSM SHALL return to IDLE; in_ready rises the following cycle (no overlap of output and input handshakes).
REQ-022 in_valid, a and b SHALL be ignored outside IDLE.
REQ-023 NaN, Inf and denormal classification SHALL NOT be performed; exceptions are handled downstream.
REQ-024 A zero operand SHALL yield P = 0 through normal iteration, with no early-out.

Reset
REQ-025 While rst = 1: state = IDLE, in_ready = 1, out_valid = 0, P = 0, exp_out = 0, sign_out = 0, counter = 0.
REQ-026 rst asserted mid-MUL or in DONE SHALL discard the operation; after release, the next operation SHALL complete correctly.

Configuration
REQ-027 Macro RADIX4_EN SHALL select unsigned radix-4 iteration when defined.
REQ-028 With RADIX4_EN: 2 multiplier bits retired per cycle (add 0, 1x, 2x or 3x multiplicand, 3x precomputed on accept), MANT_W/2 steps; out_valid first high 12 cycles after the accept edge.
REQ-029 Without RADIX4_EN: radix-2 as in REQ-018, 24-cycle latency; P SHALL be bit-identical in both builds.

Structure
REQ-030 Package fp_mult_pkg SHALL hold EXP_BIAS, MANT_W, the product width (2*MANT_W), the exponent width (10) and the FSM state enum.
REQ-031 SHALL be a single module with no sub-modules; the datapath is the accumulator, shifter and counter.

Verification
REQ-032 a=0x3F800000, b=0x3F800000 -> P=0x400000000000, exp_out=127, sign_out=0, out_valid 24 cycles after accept (12 with RADIX4_EN).
REQ-033 a=b=0x3FFFFFFF -> P=0xFFFFFE000001, exp_out=127.
REQ-034 a=0xC0000000, b=0x40400000 -> P=0x600000000000, exp_out=129, sign_out=1.
REQ-035 a=b=0x00800000 -> exp_out=10'h383 (-125), P=0x400000000000; a=0x00000000 with any b -> P=0.
REQ-036 out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-037 rst pulsed at MUL step 10 -> out_valid=0 and in_ready=1 immediately; next operation (REQ-034 operands) gives the correct result.
